aes_round_sequencer: RTL and testbench

Control block that sequences one AES encryption through the key-expansion engine and the round datapath. It accepts a key/plaintext pair over a valid/ready handshake, latches both, and restarts the expansion engine. It then steps a round counter from 0 to NR, one round per cycle, driving round-enable and first/last-round strobes to the round datapath. It captures the ciphertext on the final round and holds it on a valid/ready output handshake. It sits between the system bus wrapper and the expand/round pair.

---
 rtl/aes_round_sequencer.sv | 119 +++++++++++
 tb/tb_aes_round_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - sequences one AES encryption through key expansion and the round datapath
module aes_round_sequencer #(
    parameter int K = 128
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           abort,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [K-1:0]   in_key,
    input  logic [127:0]   in_block,
    output logic           exp_reset,
    output logic           exp_hold,
    output logic [K-1:0]   exp_key,
    output logic [127:0]   dp_block,
    output logic           dp_en,
    output logic           dp_first,
    output logic           dp_last,
    output logic [3:0]     round,
    input  logic [127:0]   dp_result,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   out_block,
    output logic           busy
);

    localparam int NR = (K == 128) ? 10 : (K == 192) ? 12 : 14;
    localparam logic [3:0] NR_L = 4'(NR);

    generate
        if (!(K == 128 || K == 192 || K == 256)) begin : g_bad_k
            $error("aes_round_sequencer: K must be 128, 192 or 256");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

    state_t         state_q, state_d;
    logic [3:0]     round_q, round_d;
    logic [K-1:0]   key_q, key_d;
    logic [127:0]   blk_q, blk_d;
    logic [127:0]   out_block_q, out_block_d;
    logic           accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            round_q     <= 4'd0;
            key_q       <= '0;
            blk_q       <= '0;
            out_block_q <= '0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            key_q       <= key_d;
            blk_q       <= blk_d;
            out_block_q <= out_block_d;
        end
    end

    // A new pair may be taken in IDLE, or in DONE in the same cycle the result is consumed.
    always_comb begin
        in_ready    = !abort && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
        accept      = in_valid && in_ready;
        state_d     = state_q;
        round_d     = round_q;
        key_d       = key_q;
        blk_d       = blk_q;
        out_block_d = out_block_q;

        if (accept) begin
            key_d = in_key;
            blk_d = in_block;
        end

        case (state_q)
            IDLE: begin
                if (accept) state_d = LOAD;
            end
            LOAD: begin
                round_d = 4'd0;
                state_d = ROUND;
            end
            ROUND: begin
                if (round_q == NR_L) begin
                    out_block_d = dp_result;
                    round_d     = 4'd0;
                    state_d     = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) state_d = accept ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over everything except reset; an aborted final round yields no result.
        if (abort) begin
            state_d     = IDLE;
            round_d     = 4'd0;
            out_block_d = out_block_q;
        end
    end

    assign exp_reset = (state_q == LOAD);
    assign exp_hold  = (state_q == DONE);
    assign dp_en     = (state_q == ROUND);
    assign dp_first  = (state_q == ROUND) && (round_q == 4'd0);
    assign dp_last   = (state_q == ROUND) && (round_q == NR_L);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign round     = round_q;
    assign exp_key   = key_q;
    assign dp_block  = blk_q;
    assign out_block = out_block_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - directed checks of the sequencer at K=128, 192 and 256
module tb_aes_round_sequencer;

    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CTB = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

    logic         clk = 1'b0;
    logic         reset;
    logic         abort;
    logic         out_ready;
    logic [255:0] key_bus;
    logic [127:0] blk;
    logic [127:0] dp_result;

    logic [2:0]   in_valid, in_ready, exp_reset, exp_hold, dp_en, dp_first, dp_last, out_valid, busy;
    logic [3:0]   round_w [3];
    logic [127:0] dp_block_w [3];
    logic [127:0] out_block_w [3];
    logic [127:0] exp_key_a;
    logic [191:0] exp_key_b;
    logic [255:0] exp_key_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_round_sequencer #(.K(128)) u_a (
        .clk(clk), .reset(reset), .abort(abort), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_key(key_bus[127:0]), .in_block(blk), .exp_reset(exp_reset[0]), .exp_hold(exp_hold[0]),
        .exp_key(exp_key_a), .dp_block(dp_block_w[0]), .dp_en(dp_en[0]), .dp_first(dp_first[0]),
        .dp_last(dp_last[0]), .round(round_w[0]), .dp_result(dp_result), .out_valid(out_valid[0]),
        .out_ready(out_ready), .out_block(out_block_w[0]), .busy(busy[0])
    );

    aes_round_sequencer #(.K(192)) u_b (
        .clk(clk), .reset(reset), .abort(abort), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_key(key_bus[191:0]), .in_block(blk), .exp_reset(exp_reset[1]), .exp_hold(exp_hold[1]),
        .exp_key(exp_key_b), .dp_block(dp_block_w[1]), .dp_en(dp_en[1]), .dp_first(dp_first[1]),
        .dp_last(dp_last[1]), .round(round_w[1]), .dp_result(dp_result), .out_valid(out_valid[1]),
        .out_ready(out_ready), .out_block(out_block_w[1]), .busy(busy[1])
    );

    aes_round_sequencer #(.K(256)) u_c (
        .clk(clk), .reset(reset), .abort(abort), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_key(key_bus), .in_block(blk), .exp_reset(exp_reset[2]), .exp_hold(exp_hold[2]),
        .exp_key(exp_key_c), .dp_block(dp_block_w[2]), .dp_en(dp_en[2]), .dp_first(dp_first[2]),
        .dp_last(dp_last[2]), .round(round_w[2]), .dp_result(dp_result), .out_valid(out_valid[2]),
        .out_ready(out_ready), .out_block(out_block_w[2]), .busy(busy[2])
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int first, second, lat, seen, busy_cnt, bad, last_cnt, exp_r;
        reset     = 1'b1;
        abort     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 3'b000;
        key_bus   = '0;
        blk       = '0;
        dp_result = ~CT;
        tick;
        tick;
        check("rst_in_ready", in_ready[0], 1);
        check("rst_out_valid", out_valid[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_round", round_w[0], 0);
        check("rst_out_block", out_block_w[0], 0);
        check("rst_strobes", {exp_reset[0], exp_hold[0], dp_en[0], dp_first[0], dp_last[0]}, 0);
        check("rst_exp_key", exp_key_a, 0);
        reset = 1'b0;

        // K=128 single block with hand-placed datapath result in round 10
        key_bus     = {128'h0, KEY};
        blk         = PT;
        in_valid[0] = 1'b1;
        #1 check("a_accept_ready", in_ready[0], 1);
        tick;
        in_valid[0] = 1'b0;
        key_bus     = '1;
        blk         = '1;
        for (int c = 1; c <= 13; c++) begin
            check($sformatf("a_exp_reset_c%0d", c), exp_reset[0], c == 1);
            check($sformatf("a_dp_first_c%0d", c), dp_first[0], c == 2);
            check($sformatf("a_dp_last_c%0d", c), dp_last[0], c == 12);
            check($sformatf("a_dp_en_c%0d", c), dp_en[0], (c >= 2) && (c <= 12));
            check($sformatf("a_out_valid_c%0d", c), out_valid[0], c == 13);
            check($sformatf("a_round_c%0d", c), round_w[0], ((c >= 2) && (c <= 12)) ? c - 2 : 0);
            dp_result = (c == 12) ? CT : ~CT;
            if (c < 13) tick;
        end
        check("a_out_block", out_block_w[0], CT);
        check("a_exp_key", exp_key_a, KEY);
        check("a_dp_block", dp_block_w[0], PT);

        // Backpressure: result must hold for 20 cycles
        for (int i = 0; i < 20; i++) begin
            dp_result = 128'(i);
            tick;
            check($sformatf("bp_out_valid_%0d", i), out_valid[0], 1);
            check($sformatf("bp_out_block_%0d", i), out_block_w[0], CT);
            check($sformatf("bp_in_ready_%0d", i), in_ready[0], 0);
            check($sformatf("bp_exp_hold_%0d", i), exp_hold[0], 1);
        end
        out_ready = 1'b1;
        #1 check("bp_release_ready", in_ready[0], 1);
        tick;
        check("bp_idle_busy", busy[0], 0);
        check("bp_idle_valid", out_valid[0], 0);

        // Back-to-back with in_valid held and out_ready high
        first       = -1;
        second      = -1;
        in_valid[0] = 1'b1;
        for (int cyc = 1; cyc <= 40 && second < 0; cyc++) begin
            tick;
            if (out_valid[0]) begin
                if (first < 0) begin
                    first = cyc;
                    check("b2b_in_ready_done", in_ready[0], 1);
                end else begin
                    second = cyc;
                end
            end
            if (first > 0 && cyc == first + 1) check("b2b_load_follows", exp_reset[0], 1);
        end
        check("b2b_first_latency", first, 13);
        check("b2b_gap", second - first, 13);

        // Abort beats a simultaneous accept
        abort = 1'b1;
        #1 check("abort_in_ready", in_ready[0], 0);
        tick;
        abort       = 1'b0;
        in_valid[0] = 1'b0;
        check("abort_a_busy", busy[0], 0);
        check("abort_a_valid", out_valid[0], 0);
        check("abort_a_round", round_w[0], 0);

        // K=192 abort at round 5, then a clean block
        out_ready   = 1'b0;
        in_valid[1] = 1'b1;
        tick;
        in_valid[1] = 1'b0;
        for (int c = 1; c < 7; c++) tick;
        check("b_round5", round_w[1], 5);
        check("b_dp_en5", dp_en[1], 1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("b_abort_busy", busy[1], 0);
        check("b_abort_round", round_w[1], 0);
        check("b_abort_valid", out_valid[1], 0);
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            tick;
            if (out_valid[1]) seen++;
        end
        check("b_no_output", seen, 0);
        dp_result   = CTB;
        in_valid[1] = 1'b1;
        tick;
        in_valid[1] = 1'b0;
        lat = -1;
        for (int cyc = 1; cyc <= 30 && lat < 0; cyc++) begin
            if (out_valid[1]) lat = cyc;
            else tick;
        end
        check("b_latency", lat, 15);
        check("b_out_block", out_block_w[1], CTB);

        // Reset while holding a result
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("rd_out_valid", out_valid[1], 0);
        check("rd_out_block", out_block_w[1], 0);
        check("rd_busy", busy[1], 0);
        check("rd_round", round_w[1], 0);

        // K=256 sweep
        out_ready   = 1'b1;
        in_valid[2] = 1'b1;
        tick;
        in_valid[2] = 1'b0;
        busy_cnt = 0;
        bad      = 0;
        last_cnt = 0;
        exp_r    = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (busy[2]) busy_cnt++;
            if (dp_en[2]) begin
                if (round_w[2] != 4'(exp_r)) bad++;
                exp_r++;
            end
            if (dp_last[2]) begin
                last_cnt++;
                if (round_w[2] != 4'd14) bad++;
            end
            tick;
        end
        check("c_busy_cycles", busy_cnt, 17);
        check("c_round_seq", bad, 0);
        check("c_round_count", exp_r, 15);
        check("c_dp_last_count", last_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
